// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mult_pkg;

   localparam int unsigned MULT_W     = 32;
   localparam int unsigned MULT_ITERS = 32;
   localparam int unsigned MULT_CNT_W = $clog2(MULT_ITERS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mult_state_e;

endpackage

// File: rtl/abs_neg.sv
// Combinational conditional two's-complement negate; with i_neg = sign bit it yields |i_val|.
module abs_neg #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] i_val,
   input  logic         i_neg,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mult_seq.sv
// Radix-2 shift-add multiplier: magnitudes multiplied over WIDTH cycles, sign applied in FIX.
module mult_seq
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sgn,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             prodv,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   mult_state_e        r_state;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [CntW-1:0]    r_cnt;
   logic               r_neg;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [2*WIDTH-1:0] w_res;
   logic [WIDTH:0]     w_addend;
   logic [WIDTH:0]     w_sum;
   logic               w_accept;

   abs_neg #(.W(WIDTH)) u_abs_a (
      .i_val (srca),
      .i_neg (sgn & srca[WIDTH-1]),
      .o_val (w_abs_a)
   );

   abs_neg #(.W(WIDTH)) u_abs_b (
      .i_val (srcb),
      .i_neg (sgn & srcb[WIDTH-1]),
      .o_val (w_abs_b)
   );

   abs_neg #(.W(2 * WIDTH)) u_fix (
      .i_val (r_acc),
      .i_neg (r_neg),
      .o_val (w_res)
   );

   // Upper half plus optional multiplicand; the carry becomes the new MSB after the shift.
   assign w_addend = r_mplier[0] ? {1'b0, r_mcand} : '0;
   assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_mcand  <= sgn ? w_abs_a : srca;
                  r_mplier <= sgn ? w_abs_b : srcb;
                  r_neg    <= sgn & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_state  <= BUSY;
               end
            end
            BUSY: begin
               r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CntW'(1);
               if (r_cnt == LastCnt) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               r_hi    <= w_res[2*WIDTH-1:WIDTH];
               r_lo    <= w_res[WIDTH-1:0];
               r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy  = (r_state == BUSY) || (r_state == FIX);
   assign prodv = (r_state == DONE);
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule
